// File: rtl/lc3_panel_loader.sv
// lc3_panel_loader: front-panel memory writer for the LC-3 board.
// The operator latches an address from the switches, then commits data words;
// each word goes out on the direct memory data-in port and the address advances.
//
// state | meaning
// IDLE  | loader inactive, memory port released
// READY | address latched, waiting for a write, a new address or exit
// WRITE | mem_we raised, addr/data held until mem_ack is sampled
module lc3_panel_loader #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic [2:0]  key_n,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] cur_addr,
  output logic [15:0] write_count,
  output logic        active,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WRITE = 2'd2
  } state_t;

  // The debounced level flips on the edge where the mismatch counter would
  // reach DEBOUNCE_CYCLES, so compare against one less.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic [2:0] key_pulse;

  // Two-flop synchroniser on the raw buttons; released level is 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= 3'b111;
      sync_b <= 3'b111;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             deb;
    logic             pulse;

    // Per-key debounce: count consecutive mismatch cycles, flip when long
    // enough, and emit a one-cycle pulse on a press (1 -> 0) flip.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt   <= '0;
        deb   <= 1'b1;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (sync_b[k] == deb) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          cnt   <= '0;
          deb   <= sync_b[k];
          pulse <= ~sync_b[k];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign key_pulse[k] = pulse;
  end

  state_t      st_q;
  state_t      st_d;
  logic [15:0] cur_d;
  logic [15:0] addr_d;
  logic [15:0] wdata_d;
  logic [15:0] cnt_d;
  logic        we_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      cur_addr    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      write_count <= '0;
    end else begin
      st_q        <= st_d;
      cur_addr    <= cur_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      mem_we      <= we_d;
      write_count <= cnt_d;
    end
  end

  // Next-state logic; key pulses arriving during WRITE are simply not looked at.
  always_comb begin
    st_d    = st_q;
    cur_d   = cur_addr;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    we_d    = mem_we;
    cnt_d   = write_count;
    unique case (st_q)
      IDLE: begin
        if (key_pulse[0]) begin
          cur_d = sw;
          st_d  = READY;
        end
      end
      READY: begin
        if (key_pulse[0]) begin
          cur_d = sw;
        end else if (key_pulse[1]) begin
          addr_d  = cur_addr;
          wdata_d = sw;
          we_d    = 1'b1;
          st_d    = WRITE;
        end else if (key_pulse[2]) begin
          st_d = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          we_d  = 1'b0;
          cur_d = cur_addr + 16'd1;
          if (write_count != 16'hFFFF) begin
            cnt_d = write_count + 16'd1;
          end
          st_d = READY;
        end
      end
      default: begin
        st_d = IDLE;
        we_d = 1'b0;
      end
    endcase
  end

  assign active = (st_q != IDLE);
  assign state  = st_q;

endmodule

// File: tb/tb_lc3_panel_loader.sv
// Bench for lc3_panel_loader with a short debounce; a memory responder acks
// writes after a programmable delay and logs each write it sees.
module tb_lc3_panel_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic [2:0]  key_n = 3'b111;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] cur_addr;
  logic [15:0] write_count;
  logic        active;
  logic [1:0]  state;

  lc3_panel_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key_n(key_n), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cur_addr(cur_addr), .write_count(write_count), .active(active), .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ack_delay = 1;

  // writes observed on the memory port
  logic [15:0] wr_a_q[$];
  logic [15:0] wr_d_q[$];
  int          wr_len_q[$];
  bit          wr_st_q[$];

  // reference model
  logic [1:0]  m_state = 2'd0;
  logic [15:0] m_cur = '0;
  logic [15:0] m_cnt = '0;
  logic [15:0] ex_a_q[$];
  logic [15:0] ex_d_q[$];
  int          ex_len_q[$];

  int          hi_len = 0;
  logic [15:0] cap_a = '0;
  logic [15:0] cap_d = '0;
  bit          cap_st = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory responder: acks after ack_delay cycles, records addr/data/length
  initial begin
    forever begin
      tick();
      if (mem_we === 1'b1) begin
        hi_len++;
        if (hi_len == 1) begin
          cap_a  = mem_addr;
          cap_d  = mem_wdata;
          cap_st = 1'b1;
        end else if (mem_addr !== cap_a || mem_wdata !== cap_d) begin
          cap_st = 1'b0;
        end
        mem_ack = (hi_len == ack_delay + 1);
      end else begin
        if (hi_len != 0) begin
          wr_a_q.push_back(cap_a);
          wr_d_q.push_back(cap_d);
          wr_len_q.push_back(hi_len);
          wr_st_q.push_back(cap_st);
        end
        hi_len  = 0;
        mem_ack = 1'b0;
      end
    end
  end

  task automatic model_press(input logic [2:0] mask, input logic [15:0] val);
    if (mask[0]) begin
      m_cur   = val;
      m_state = 2'd1;
    end else if (m_state == 2'd1 && mask[1]) begin
      ex_a_q.push_back(m_cur);
      ex_d_q.push_back(val);
      ex_len_q.push_back(ack_delay + 1);
      m_cur = m_cur + 16'd1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (m_state == 2'd1 && mask[2]) begin
      m_state = 2'd0;
    end
  endtask

  task automatic press(input logic [2:0] mask, input logic [15:0] val);
    model_press(mask, val);
    sw    = val;
    key_n = ~mask;
    repeat (10) tick();
    key_n = 3'b111;
    repeat (10) tick();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 16'(state), 16'(m_state));
    chk({tag, ".active"}, 16'(active), 16'(m_state != 2'd0));
    chk({tag, ".cur_addr"}, cur_addr, m_cur);
    chk({tag, ".write_count"}, write_count, m_cnt);
    chk({tag, ".mem_we"}, 16'(mem_we), 16'd0);
    chk({tag, ".nwrites"}, 16'(wr_a_q.size()), 16'(ex_a_q.size()));
    while (wr_a_q.size() > 0 && ex_a_q.size() > 0) begin
      chk({tag, ".wr_addr"}, wr_a_q.pop_front(), ex_a_q.pop_front());
      chk({tag, ".wr_data"}, wr_d_q.pop_front(), ex_d_q.pop_front());
      chk({tag, ".we_len"}, 16'(wr_len_q.pop_front()), 16'(ex_len_q.pop_front()));
      chk({tag, ".wr_stable"}, 16'(wr_st_q.pop_front()), 16'd1);
    end
    wr_a_q.delete(); wr_d_q.delete(); wr_len_q.delete(); wr_st_q.delete();
    ex_a_q.delete(); ex_d_q.delete(); ex_len_q.delete();
  endtask

  logic [2:0] mask_tab [10] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd4, 3'd3, 3'd6, 3'd5, 3'd2, 3'd7};

  initial begin
    // reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst.mem_addr", mem_addr, 16'h0000);
    chk("rst.mem_wdata", mem_wdata, 16'h0000);
    check_all("rst");

    // glitch of 3 cycles is filtered
    sw    = 16'h3000;
    key_n = 3'b110;
    repeat (3) tick();
    key_n = 3'b111;
    repeat (10) tick();
    check_all("glitch");

    // clean press acts on edge 7 after the fall, and only once
    key_n = 3'b110;
    repeat (6) tick();
    chk("lat.edge6_state", 16'(state), 16'd0);
    tick();
    chk("lat.edge7_state", 16'(state), 16'd1);
    chk("lat.edge7_cur", cur_addr, 16'h3000);
    sw = 16'h3100;
    repeat (3) tick();
    key_n = 3'b111;
    repeat (10) tick();
    m_state = 2'd1;
    m_cur   = 16'h3000;
    check_all("lat");

    // sequential load with a one-cycle ack
    ack_delay = 1;
    press(3'b001, 16'h3000);
    press(3'b010, 16'h1234);
    press(3'b010, 16'h5678);
    check_all("seq");

    // slow ack: mem_we high for exactly 6 cycles
    ack_delay = 5;
    press(3'b010, 16'hBEEF);
    check_all("slow5");

    // long WRITE with another write press and an addr press arriving inside it
    ack_delay = 14;
    model_press(3'b010, 16'h0BAD);
    sw    = 16'h0BAD;
    key_n = 3'b101;
    repeat (5) tick();
    key_n = 3'b111;
    repeat (2) tick();
    chk("slow14.we_up", 16'(mem_we), 16'd1);
    chk("slow14.addr", mem_addr, m_cur - 16'd1);
    sw = 16'h7777;
    repeat (4) tick();
    key_n = 3'b100;
    repeat (6) tick();
    key_n = 3'b111;
    repeat (12) tick();
    check_all("slow14");

    // address wrap
    ack_delay = 2;
    press(3'b001, 16'hFFFF);
    press(3'b010, 16'hAAAA);
    press(3'b010, 16'hBBBB);
    check_all("wrap");

    // ignored presses and priority
    press(3'b100, 16'h0000);
    check_all("exit1");
    press(3'b010, 16'h1111);
    check_all("idle_wr");
    press(3'b001, 16'h2000);
    press(3'b011, 16'h4000);
    check_all("prio_aw");
    press(3'b110, 16'h5555);
    check_all("prio_we");
    press(3'b100, 16'h0000);
    check_all("exit2");

    // randomized presses against the model
    for (int i = 0; i < 24; i++) begin
      ack_delay = int'($urandom_range(8, 1));
      press(mask_tab[$urandom_range(9, 0)], 16'($urandom));
      check_all($sformatf("rnd%0d", i));
    end

    // reset while a write is pending
    press(3'b001, 16'h5000);
    ack_delay = 1000;
    sw    = 16'h9999;
    key_n = 3'b101;
    repeat (8) tick();
    chk("rstw.we_up", 16'(mem_we), 16'd1);
    rst_n = 1'b0;
    tick();
    chk("rstw.mem_we", 16'(mem_we), 16'd0);
    chk("rstw.state", 16'(state), 16'd0);
    chk("rstw.cur_addr", cur_addr, 16'h0000);
    chk("rstw.write_count", write_count, 16'h0000);
    chk("rstw.active", 16'(active), 16'd0);
    key_n = 3'b111;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    wr_a_q.delete(); wr_d_q.delete(); wr_len_q.delete(); wr_st_q.delete();
    ex_a_q.delete(); ex_d_q.delete(); ex_len_q.delete();
    m_state = 2'd0;
    m_cur   = '0;
    m_cnt   = '0;
    ack_delay = 3;
    press(3'b001, 16'h0100);
    press(3'b010, 16'hCAFE);
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
